// File: rtl/tone_period_meter_if.sv
// Signal bundle between a tone source/monitor and tone_period_meter:
// the wave under measurement, its enable, and the measured tone code.
interface tone_period_meter_if;
  logic        sig_in;
  logic        enable;
  logic [15:0] maxcount;
  logic        meas_valid;
  logic        locked;
  logic        timeout;

  modport master (
    output sig_in, enable,
    input  maxcount, meas_valid, locked, timeout
  );

  modport slave (
    input  sig_in, enable,
    output maxcount, meas_valid, locked, timeout
  );
endinterface

// File: rtl/tone_period_meter.sv
// Measures the period of a square wave in clk cycles and reports the
// half-period code that makes the clock divider regenerate the same tone.
// state   | meaning
// IDLE    | waiting for a first rising edge, counter cleared
// MEASURE | counting cycles since the last accepted rising edge
module tone_period_meter #(
  parameter int CNT_W      = 17,
  parameter int MIN_PERIOD = 4,
  parameter int TOL        = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tone_period_meter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] PCNT_MAX = '1;
  localparam logic [CNT_W-1:0] PCNT_MIN = CNT_W'(MIN_PERIOD);
  localparam logic [15:0]      TOL_W    = 16'(TOL);

  state_t           state_q;
  logic [1:0]       sync_q;
  logic             sig_d_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [15:0]      maxcount_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             timeout_q;

  logic        sig_s;
  logic        rise;
  logic        pcnt_sat;
  logic        long_enough;
  logic        within_tol;
  logic [15:0] half_d;
  logic [15:0] delta_d;

  assign sig_s       = sync_q[1];
  assign rise        = sig_s & ~sig_d_q;
  assign pcnt_sat    = (pcnt_q == PCNT_MAX);
  assign long_enough = (pcnt_q >= PCNT_MIN);
  assign half_d      = 16'(pcnt_q >> 1);
  assign delta_d     = (half_d >= maxcount_q) ? (half_d - maxcount_q) : (maxcount_q - half_d);
  // a previous code of 0 is silence, so there is nothing to lock against
  assign within_tol  = (maxcount_q != 16'd0) && (delta_d <= TOL_W);

  // synchronizer runs even while disabled so re-enabling on a high input
  // does not fabricate an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.sig_in};
      sig_d_q <= sig_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      maxcount_q   <= 16'd0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q  <= IDLE;
        pcnt_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= MEASURE;
              pcnt_q  <= CNT_W'(1);
            end
          end
          MEASURE: begin
            if (rise && long_enough) begin
              maxcount_q   <= half_d;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b0;
              locked_q     <= within_tol;
              pcnt_q       <= CNT_W'(1);
            end else if (pcnt_sat) begin
              // saturated with no edge this cycle: the tone has gone silent
              maxcount_q   <= 16'd0;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b1;
              locked_q     <= 1'b0;
              pcnt_q       <= '0;
              state_q      <= IDLE;
            end else begin
              pcnt_q <= pcnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            pcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.maxcount   = maxcount_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter; a 12-bit period counter keeps the timeout
// reachable within a short run while leaving room for 600-cycle periods.
module tb_tone_period_meter;
  localparam int CNT_W_TB = 12;
  localparam int SAT      = (1 << CNT_W_TB) - 1;
  localparam int MIN_P    = 4;
  localparam int TOL_P    = 2;
  localparam int NV       = 12;

  typedef struct {
    longint      cyc;
    logic [15:0] mc;
    logic        lk;
    logic        to;
  } ev_t;

  typedef struct {
    int          hi;
    int          lo;
    bit          glitch;
    logic [15:0] exp_mc;
    logic        exp_lk;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  ev_t    exp_q[$];
  ev_t    act_q[$];
  vec_t   tbl[NV];

  // reference model: event-level view of accepted rises
  bit          m_en;
  bit          m_active;
  longint      m_last;
  logic [15:0] m_mc;
  longint      last_drv;

  tone_period_meter_if bus();

  tone_period_meter #(
    .CNT_W(CNT_W_TB),
    .MIN_PERIOD(MIN_P),
    .TOL(TOL_P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && bus.meas_valid) begin
      e.cyc = cyc;
      e.mc  = bus.maxcount;
      e.lk  = bus.locked;
      e.to  = bus.timeout;
      act_q.push_back(e);
    end
  end

  // A rise driven at cycle n is acted on 3 cycles later, so outputs show
  // at n+3; silence is declared SAT cycles after that for the last accepted rise.
  function automatic void m_advance(input longint edge_cyc);
    ev_t e;
    if (m_active && (m_last + 3 + SAT < edge_cyc)) begin
      e.cyc = m_last + 3 + SAT;
      e.mc  = 16'd0;
      e.lk  = 1'b0;
      e.to  = 1'b1;
      exp_q.push_back(e);
      m_active = 1'b0;
      m_mc     = 16'd0;
    end
  endfunction

  function automatic void m_rise(input longint n);
    ev_t    e;
    longint gap;
    longint diff;
    m_advance(n + 3);
    if (!m_en) return;
    if (!m_active) begin
      m_active = 1'b1;
      m_last   = n;
      return;
    end
    gap = n - m_last;
    if (gap < MIN_P) return;
    e.cyc = n + 3;
    e.mc  = 16'(gap / 2);
    diff  = longint'(e.mc) - longint'(m_mc);
    if (diff < 0) diff = -diff;
    e.lk  = (m_mc != 16'd0) && (diff <= TOL_P);
    e.to  = 1'b0;
    exp_q.push_back(e);
    m_mc   = e.mc;
    m_last = n;
  endfunction

  function automatic void m_enable(input bit v, input longint m);
    if (!v) begin
      m_advance(m + 1);
      m_active = 1'b0;
    end
    m_en = v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sig(input bit v);
    if (v && !bus.sig_in) begin
      m_rise(cyc);
      last_drv = cyc;
    end
    bus.sig_in = v;
  endtask

  task automatic set_en(input bit v);
    m_enable(v, cyc);
    bus.enable = v;
  endtask

  task automatic period(input int hi, input int lo);
    set_sig(1'b1);
    tick(hi);
    set_sig(1'b0);
    tick(lo);
  endtask

  task automatic glitch_period(input int hi, input int lo);
    set_sig(1'b1);
    tick(2);
    set_sig(1'b0);
    tick(1);
    set_sig(1'b1);
    tick(hi - 3);
    set_sig(1'b0);
    tick(lo);
  endtask

  task automatic next_rise(input int gap);
    longint t;
    t = last_drv + gap;
    if (bus.sig_in) begin
      while (cyc < last_drv + gap / 2) tick(1);
      set_sig(1'b0);
    end
    while (cyc < t) tick(1);
    set_sig(1'b1);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_events(input string name);
    int n;
    m_advance(cyc + 1);
    n = (exp_q.size() > act_q.size()) ? exp_q.size() : act_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= exp_q.size() || i >= act_q.size()) begin
        errors++;
        $display("FAIL %s[%0d]: event count actual=%0d required=%0d",
                 name, i, act_q.size(), exp_q.size());
        break;
      end else if (act_q[i].cyc != exp_q[i].cyc || act_q[i].mc != exp_q[i].mc ||
                   act_q[i].lk != exp_q[i].lk || act_q[i].to != exp_q[i].to) begin
        errors++;
        $display("FAIL %s[%0d]: actual cyc=%0d mc=%0d lk=%0b to=%0b required cyc=%0d mc=%0d lk=%0b to=%0b",
                 name, i, act_q[i].cyc, act_q[i].mc, act_q[i].lk, act_q[i].to,
                 exp_q[i].cyc, exp_q[i].mc, exp_q[i].lk, exp_q[i].to);
      end
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    tbl[0]  = '{100, 100, 1'b0, 16'd100, 1'b0};
    tbl[1]  = '{100, 100, 1'b0, 16'd100, 1'b1};
    tbl[2]  = '{100, 100, 1'b0, 16'd100, 1'b1};
    tbl[3]  = '{100, 101, 1'b0, 16'd100, 1'b1};
    tbl[4]  = '{100, 100, 1'b0, 16'd100, 1'b1};
    tbl[5]  = '{101, 102, 1'b0, 16'd101, 1'b1};
    tbl[6]  = '{100, 100, 1'b0, 16'd100, 1'b1};
    tbl[7]  = '{101, 102, 1'b0, 16'd101, 1'b1};
    tbl[8]  = '{150, 150, 1'b0, 16'd150, 1'b0};
    tbl[9]  = '{150, 150, 1'b0, 16'd150, 1'b1};
    tbl[10] = '{150, 150, 1'b1, 16'd150, 1'b1};
    tbl[11] = '{100, 100, 1'b0, 16'd100, 1'b0};

    m_en       = 1'b1;
    m_active   = 1'b0;
    m_last     = 0;
    m_mc       = 16'd0;
    last_drv   = 0;
    bus.sig_in = 1'b0;
    bus.enable = 1'b1;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    tick(3);
    chk("reset_maxcount", bus.maxcount, 0);
    chk("reset_meas_valid", bus.meas_valid, 0);
    chk("reset_locked", bus.locked, 0);
    chk("reset_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].glitch) glitch_period(tbl[i].hi, tbl[i].lo);
      else               period(tbl[i].hi, tbl[i].lo);
    end
    set_sig(1'b1);
    tick(5);
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (i >= act_q.size()) begin
        errors++;
        $display("FAIL table[%0d]: missing measurement, got %0d events", i, act_q.size());
      end else if (act_q[i].mc != tbl[i].exp_mc || act_q[i].lk != tbl[i].exp_lk) begin
        errors++;
        $display("FAIL table[%0d]: actual mc=%0d lk=%0b required mc=%0d lk=%0b",
                 i, act_q[i].mc, act_q[i].lk, tbl[i].exp_mc, tbl[i].exp_lk);
      end
    end
    check_events("table_model");

    tick(95);
    set_sig(1'b0);
    tick(SAT + 20);
    check_events("timeout");
    chk("timeout_maxcount", bus.maxcount, 0);
    chk("timeout_flag", bus.timeout, 1);
    chk("timeout_locked", bus.locked, 0);
    repeat (3) period(100, 100);
    set_sig(1'b1);
    tick(5);
    check_events("restart");
    chk("restart_timeout", bus.timeout, 0);
    chk("restart_maxcount", bus.maxcount, 100);
    chk("restart_locked", bus.locked, 1);

    tick(55);
    set_en(1'b0);
    tick(2);
    chk("disable_locked", bus.locked, 0);
    chk("disable_maxcount", bus.maxcount, m_mc);
    tick(38);
    set_sig(1'b0);
    tick(10);
    set_en(1'b1);
    tick(90);
    period(100, 100);
    period(100, 100);
    set_sig(1'b1);
    tick(5);
    check_events("enable");

    tick(45);
    rst_n = 1'b0;
    #1;
    chk("async_rst_maxcount", bus.maxcount, 0);
    chk("async_rst_meas_valid", bus.meas_valid, 0);
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_timeout", bus.timeout, 0);
    m_active = 1'b0;
    m_mc     = 16'd0;
    tick(50);
    set_sig(1'b0);
    tick(10);
    rst_n = 1'b1;
    tick(90);
    period(100, 100);
    period(100, 100);
    set_sig(1'b1);
    tick(5);
    check_events("reset_mid");

    next_rise(300);
    next_rise(MIN_P);
    next_rise(3);
    next_rise(2);
    next_rise(SAT);
    next_rise(SAT + 1);
    tick(5);
    chk("sat_gap_timeout", bus.timeout, 1);
    next_rise(200);
    tick(5);
    chk("after_sat_timeout", bus.timeout, 0);
    chk("after_sat_maxcount", bus.maxcount, 100);
    check_events("boundary");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) next_rise(int'($urandom_range(2, 6)));
      else                           next_rise(int'($urandom_range(7, 600)));
    end
    tick(5);
    check_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tone_period_meter.md
# tone_period_meter

Measures the period of an incoming square wave, such as a speaker drive line or an external tone, in system-clock cycles. It reports the result as the 16-bit half-period count, `maxcount`. Feeding that value into the team's clock divider reproduces the same tone, so this block is the inverse of the divider. It sits beside the SpeakerDriver and produces the tone code for capture, compare and loopback checks.

## Interface
- `CNT_W`, 17: period counter width. Saturation value 2^CNT_W−1 defines the timeout.
- `MIN_PERIOD`, 4: rising-edge spacings shorter than this many clk cycles are glitches and are rejected.
- `TOL`, 2: maximum |new − previous| `maxcount` difference that counts as a stable tone.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `sig_in`, input, 1: square wave under measurement; asynchronous to `clk`.
- `enable`, input, 1: measurement enable.
- `maxcount`, output, 16: last measured half-period (period >> 1); 0 means silence.
- `meas_valid`, output, 1: one-cycle strobe when `maxcount` / `locked` / `timeout` update.
- `locked`, output, 1: the last two measurements agree within `TOL`.
- `timeout`, output, 1: sticky flag for no edge within the counter range; clears on the next good measurement.

## Operation
- **Input synchronizer.** 2-FF synchronizer produces `sig_s`; a further register produces `sig_d`; `rise = sig_s & ~sig_d`.
- **State machine.** Two states, IDLE and MEASURE. The counter `pcnt` is CNT_W bits.
- **IDLE.** `pcnt` = 0. A `rise` with `enable` = 1 moves to MEASURE and sets `pcnt` = 1. The first edge produces no measurement.
- **MEASURE, counting.** `pcnt` increments every cycle and saturates at all-ones.
- **MEASURE, valid edge.** On `rise` with `pcnt` ≥ MIN_PERIOD:
  - `maxcount` ← `pcnt[16:1]`, truncated.
  - `meas_valid` pulses.
  - `timeout` ← 0.
  - `locked` ← 1 if the previous `maxcount` ≠ 0 and |new − previous| ≤ TOL, else 0.
  - `pcnt` ← 1.
- **MEASURE, glitch edge.** On `rise` with `pcnt` < MIN_PERIOD: the edge is ignored; the counter keeps running and no outputs change.
- **Timeout.** When `pcnt` is saturated and there is no `rise` that cycle:
  - `maxcount` ← 0, `locked` ← 0, `timeout` ← 1.
  - `meas_valid` pulses once.
  - The block moves to IDLE.
- **Enable low.** Synchronously forces IDLE, `pcnt` ← 0, `locked` ← 0. `maxcount` and `timeout` hold. Edges are ignored while disabled.
- **Width rule.** Period P (cycles between consecutive accepted rises) gives `maxcount` = floor(P/2). The maximum reportable value is 65535.

## Timing
- **Reset values.** `maxcount` = 0, `meas_valid` = 0, `locked` = 0, `timeout` = 0; state IDLE; synchronizer and `pcnt` = 0.
- **Edge-detect latency.** `sig_in` rising before clk edge k gives `rise` high during cycle k+2.
- **Output latency.** Outputs update, and `meas_valid` is high, in the cycle after the `rise` cycle.
- **Period definition.** A `rise` at cycle t0 and the next at t0+P gives `pcnt` = P at t0+P.
- **Simultaneous events.** `enable` = 0 beats `rise`. `rise` in the saturation cycle is a valid measurement (`maxcount` 65535), not a timeout.
- **Reset mid-measurement.** Outputs clear immediately, asynchronously. The first `rise` after release re-enters MEASURE with no output.
- **Steady-state behaviour.** `meas_valid` strobes once per input period.

## Test plan
- **Loopback from a divider-style wave.** `sig_in` is a square wave with half-period 100 clk. Required response:
  - `meas_valid` every 200 cycles with `maxcount` = 100.
  - `locked` = 0 on the first measurement and 1 from the second onward.
- **Odd period.** Period 201 → `maxcount` = 100. Alternating periods 200/203 → `maxcount` 100/101 and `locked` stays 1.
- **Frequency step.** Half-period changes 100 → 150. Required response:
  - The first new measurement gives `maxcount` = 150, `locked` = 0.
  - The next gives `locked` = 1.
- **Glitch rejection.** During a 200-cycle period, insert a 1-cycle low then high pulse, so rises are 3 cycles apart. There is no `meas_valid` at the glitch, and the next `maxcount` equals the half-period measured from the last accepted rise.
- **Timeout.** After a valid measurement of 100, hold `sig_in` low. After 131071 cycles, one `meas_valid` pulse with `maxcount` = 0, `timeout` = 1, `locked` = 0. Restarting the tone gives two rises, then `maxcount` = 100 and `timeout` = 0.
- **Reset and enable mid-measurement.**
  - Assert `rst_n` = 0 mid-period: all outputs are 0 at once.
  - Drop `enable` for 50 cycles mid-period: no `meas_valid`, `maxcount` holds, `locked` = 0.
  - After re-enable: the first rise produces no output; the second gives the correct `maxcount`.
